// File: rtl/rr_arbiter4_dec.sv
// rr_arbiter4_dec: four-requester round-robin arbiter with bounded hold.
// The owner index and valid flag are registered; the one-hot grant is
// derived from them by a 2-to-4 decoder, so the grant can never be
// multi-hot and only changes at clock edges.

// 2-to-4 one-hot decoder with enable; all zeros when disabled.
module decoder2to4withEnable (
    input  logic [1:0] in_i,
    input  logic       en_i,
    output logic [3:0] out_o
);

    // Drive exactly one output bit when enabled.
    always_comb begin
        out_o = 4'b0000;
        if (en_i) begin
            out_o[in_i] = 1'b1;
        end
    end

endmodule

module rr_arbiter4_dec #(
    parameter int HOLD_MAX = 8,
    parameter int CW       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid,
    output logic       busy
);

    localparam logic [CW-1:0] HOLD_C = CW'(HOLD_MAX);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state_q;
    logic [1:0]      gnt_idx_q;
    logic            gnt_valid_q;
    logic            busy_q;
    logic [1:0]      ptr_q;
    logic [CW-1:0]   cnt_q;

    logic [3:0]      gnt_dec;
    logic [3:0]      other_req;
    logic            own_req;
    logic [2:0]      any_win;
    logic [2:0]      oth_win;

    // Round-robin scan: first set bit of r starting at p, wrapping mod 4.
    // Result is {found, index}. The loop runs from the farthest offset
    // down so the nearest candidate is the last one written.
    function automatic logic [2:0] rr_scan(input logic [3:0] r, input logic [1:0] p);
        logic [2:0] res;
        logic [1:0] n;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            n = p + 2'(i);
            if (r[n]) begin
                res = {1'b1, n};
            end
        end
        return res;
    endfunction

    // Hold counter increment that saturates at HOLD_MAX instead of wrapping.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        if (c >= HOLD_C) begin
            return HOLD_C;
        end
        return c + 1'b1;
    endfunction

    // The decoder output doubles as the owner mask while a grant is active.
    decoder2to4withEnable u_dec (
        .in_i  (gnt_idx_q),
        .en_i  (gnt_valid_q),
        .out_o (gnt_dec)
    );

    // Winner candidates: any requester, and any requester other than the owner.
    always_comb begin
        own_req   = |(req & gnt_dec);
        other_req = req & ~gnt_dec;
        any_win   = rr_scan(req, ptr_q);
        oth_win   = rr_scan(other_req, ptr_q);
    end

    // Arbitration FSM: grant on request, hold while owner requests,
    // hand over on release, and force rotation after HOLD_MAX under contention.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_idx_q   <= 2'd0;
            gnt_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            ptr_q       <= 2'd0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_win[2]) begin
                        gnt_idx_q   <= any_win[1:0];
                        gnt_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                        cnt_q       <= CW'(1);
                        ptr_q       <= any_win[1:0] + 2'd1;
                        state_q     <= GRANT;
                    end
                end
                GRANT: begin
                    if (!own_req) begin
                        if (oth_win[2]) begin
                            // Owner released while others wait: hand over with no dead cycle.
                            gnt_idx_q <= oth_win[1:0];
                            cnt_q     <= CW'(1);
                            ptr_q     <= oth_win[1:0] + 2'd1;
                        end else begin
                            // Nobody left: go idle, keep the last index visible.
                            gnt_valid_q <= 1'b0;
                            busy_q      <= 1'b0;
                            cnt_q       <= '0;
                            state_q     <= IDLE;
                        end
                    end else if ((cnt_q >= HOLD_C) && oth_win[2]) begin
                        // Hold budget used up and someone is waiting: preempt.
                        gnt_idx_q <= oth_win[1:0];
                        cnt_q     <= CW'(1);
                        ptr_q     <= oth_win[1:0] + 2'd1;
                    end else begin
                        cnt_q <= sat_inc(cnt_q);
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    gnt_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    cnt_q       <= '0;
                end
            endcase
        end
    end

    assign gnt       = gnt_dec;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_rr_arbiter4_dec.sv
// Testbench for rr_arbiter4_dec: directed scenarios plus randomized traffic,
// all checked against a cycle-level behavioural model of the arbitration rules.
module tb_rr_arbiter4_dec;

    localparam int HOLD = 8;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       busy;

    int n_cmp;
    int n_err;

    // Behavioural model state (plain integers).
    int m_valid;
    int m_idx;
    int m_ptr;
    int m_cnt;

    rr_arbiter4_dec #(.HOLD_MAX(HOLD), .CW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // First requester found going round from position p; -1 when none.
    function automatic int first_from(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    // Expected {gnt, gnt_idx, gnt_valid, busy} from the model.
    function automatic logic [7:0] exp_vec();
        logic [3:0] g;
        g = (m_valid != 0) ? (4'b0001 << m_idx) : 4'b0000;
        return {g, 2'(m_idx), (m_valid != 0), (m_valid != 0)};
    endfunction

    // Advance the model by one clock edge.
    task automatic model_edge(input logic r_rst, input logic [3:0] r);
        int w;
        logic [3:0] oth;
        if (r_rst) begin
            m_valid = 0; m_idx = 0; m_ptr = 0; m_cnt = 0;
        end else if (m_valid == 0) begin
            w = first_from(r, m_ptr);
            if (w >= 0) begin
                m_idx = w; m_valid = 1; m_cnt = 1; m_ptr = (w + 1) % 4;
            end
        end else begin
            oth = r;
            oth[m_idx] = 1'b0;
            w = first_from(oth, m_ptr);
            if (!r[m_idx]) begin
                if (w >= 0) begin
                    m_idx = w; m_cnt = 1; m_ptr = (w + 1) % 4;
                end else begin
                    m_valid = 0; m_cnt = 0;
                end
            end else if (m_cnt >= HOLD && w >= 0) begin
                m_idx = w; m_cnt = 1; m_ptr = (w + 1) % 4;
            end else begin
                m_cnt = (m_cnt + 1 > HOLD) ? HOLD : m_cnt + 1;
            end
        end
    endtask

    // Drive one cycle: apply inputs, wait for the edge, update model, settle.
    task automatic cyc(input logic r_rst, input logic [3:0] r);
        rst = r_rst;
        req = r;
        @(posedge clk);
        model_edge(r_rst, r);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            cyc(1'b1, 4'b1111);
            n_cmp++;
            if ({gnt, gnt_idx, gnt_valid, busy} !== 8'b0000_00_0_0) begin
                n_err++;
                $display("FAIL reset_state cyc%0d got=%b want=%b", i, {gnt, gnt_idx, gnt_valid, busy}, 8'b0000_00_0_0);
            end
        end
        cyc(1'b0, 4'b1111);
        n_cmp++;
        if ({gnt, gnt_idx} !== {4'b0001, 2'd0}) begin
            n_err++;
            $display("FAIL reset_first_grant got gnt=%b idx=%0d want gnt=0001 idx=0", gnt, gnt_idx);
        end
    endtask

    task automatic test_single();
        cyc(1'b1, 4'b0000);
        for (int i = 0; i < 21; i++) begin
            cyc(1'b0, 4'b0100);
            n_cmp++;
            if (gnt !== 4'b0100 || {gnt, gnt_idx, gnt_valid, busy} !== exp_vec()) begin
                n_err++;
                $display("FAIL single_hold cyc%0d got=%b want gnt=0100 model=%b", i, {gnt, gnt_idx, gnt_valid, busy}, exp_vec());
            end
        end
        cyc(1'b0, 4'b0000);
        n_cmp++;
        if ({gnt, gnt_idx, gnt_valid, busy} !== {4'b0000, 2'd2, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL single_release got=%b want=%b", {gnt, gnt_idx, gnt_valid, busy}, {4'b0000, 2'd2, 1'b0, 1'b0});
        end
    endtask

    task automatic test_rotation();
        logic [3:0] want;
        cyc(1'b1, 4'b0000);
        for (int i = 0; i < 40; i++) begin
            cyc(1'b0, 4'b1111);
            want = 4'b0001 << ((i / HOLD) % 4);
            n_cmp++;
            if (gnt !== want || {gnt, gnt_idx, gnt_valid, busy} !== exp_vec()) begin
                n_err++;
                $display("FAIL rotation cyc%0d got gnt=%b want gnt=%b", i, gnt, want);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] seq_req [3];
        logic [3:0] seq_gnt [3];
        seq_req[0] = 4'b0001; seq_gnt[0] = 4'b0001;
        seq_req[1] = 4'b1010; seq_gnt[1] = 4'b0010;
        seq_req[2] = 4'b1000; seq_gnt[2] = 4'b1000;
        cyc(1'b1, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, seq_req[i]);
            n_cmp++;
            if (gnt !== seq_gnt[i] || gnt_valid !== 1'b1) begin
                n_err++;
                $display("FAIL back_to_back step%0d got gnt=%b vld=%b want gnt=%b vld=1", i, gnt, gnt_valid, seq_gnt[i]);
            end
        end
    endtask

    task automatic test_fairness_idle();
        cyc(1'b1, 4'b0000);
        cyc(1'b0, 4'b0100);
        cyc(1'b0, 4'b0000);
        for (int i = 0; i < 3; i++) cyc(1'b0, 4'b0000);
        cyc(1'b0, 4'b0101);
        n_cmp++;
        if (gnt !== 4'b0001) begin
            n_err++;
            $display("FAIL fair_after_idle got gnt=%b want gnt=0001", gnt);
        end
        for (int i = 0; i < 8; i++) cyc(1'b0, 4'b0101);
        n_cmp++;
        if (gnt !== 4'b0100 || {gnt, gnt_idx, gnt_valid, busy} !== exp_vec()) begin
            n_err++;
            $display("FAIL fair_next_contention got gnt=%b want gnt=0100", gnt);
        end
    endtask

    task automatic test_mid_reset();
        cyc(1'b1, 4'b0000);
        for (int i = 0; i < 5; i++) cyc(1'b0, 4'b1000);
        cyc(1'b1, 4'b1000);
        n_cmp++;
        if ({gnt, gnt_valid, busy} !== 6'b0000_0_0) begin
            n_err++;
            $display("FAIL midreset_drop got gnt=%b vld=%b busy=%b want 0000/0/0", gnt, gnt_valid, busy);
        end
        cyc(1'b0, 4'b1000);
        n_cmp++;
        if (gnt !== 4'b1000) begin
            n_err++;
            $display("FAIL midreset_regrant got gnt=%b want gnt=1000", gnt);
        end
        // Owner held for 8 cycles in total (cnt restarted at 1) before rotation.
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 4'b1001);
            n_cmp++;
            if ({gnt, gnt_idx, gnt_valid, busy} !== exp_vec() || gnt !== ((i < 7) ? 4'b1000 : 4'b0001)) begin
                n_err++;
                $display("FAIL midreset_hold cyc%0d got gnt=%b model=%b", i, gnt, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        logic       r_rst;
        logic [3:0] r;
        cyc(1'b1, 4'b0000);
        for (int i = 0; i < 600; i++) begin
            r_rst = ($urandom_range(0, 49) == 0);
            // Bias toward dense request patterns so preemption is exercised.
            r = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : (4'b1111 & ~(4'b0001 << $urandom_range(0, 4)));
            cyc(r_rst, r);
            n_cmp++;
            if ({gnt, gnt_idx, gnt_valid, busy} !== exp_vec()) begin
                n_err++;
                $display("FAIL random cyc%0d rst=%b req=%b got=%b want=%b", i, r_rst, r, {gnt, gnt_idx, gnt_valid, busy}, exp_vec());
            end
        end
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        m_valid = 0; m_idx = 0; m_ptr = 0; m_cnt = 0;
        rst     = 1'b1;
        req     = 4'b0000;
        test_reset();
        test_single();
        test_rotation();
        test_back_to_back();
        test_fairness_idle();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rr_arbiter4_dec.md
Name: rr_arbiter4_dec

Overview:
- Four-requester round-robin arbiter for one shared resource.
- Registers a 2-bit winner index and drives it through an internal decoder2to4withEnable instance, with En = grant-valid, to produce the one-hot grant vector.
- Holds a grant while the owner keeps requesting. Preempts the owner after HOLD_MAX consecutive cycles if another requester is waiting.
- Sits between the four bus masters and the shared-resource select lines.

Parameters:
- HOLD_MAX, 8, max consecutive grant cycles before forced rotation when contention exists; legal range 1..255.
- CW, 8, hold-counter width; must satisfy 2**CW > HOLD_MAX.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request vector; bit n = requester n.
- gnt  output  4  one-hot grant = decoder2to4withEnable(gnt_idx, En=gnt_valid); 4'b0000 when gnt_valid=0.
- gnt_idx  output  2  registered index of current owner; holds last value when idle.
- gnt_valid  output  1  registered; 1 while a grant is active.
- busy  output  1  = gnt_valid; registered copy provided for status fabric.

Behaviour:
- Clock and reset:
  - One clock: clk.
  - rst is synchronous and active-high.
  - While rst=1 at a rising edge, next state is: state=IDLE, gnt_idx=0, gnt_valid=0, busy=0, gnt=0000, ptr=0, cnt=0.
  - rst asserted mid-grant drops the grant at that edge; no partial hold is retained.
- Internal state:
  - state ∈ {IDLE, GRANT}.
  - ptr[1:0] is the highest-priority candidate.
  - cnt[CW-1:0] counts cycles the current owner has held the grant.
- Winner selection (combinational): scan req starting at ptr, then ptr+1, ptr+2, ptr+3, all mod 4; the first set bit wins. "other" means req with the current owner's bit masked off, scanned the same way from ptr.
- IDLE:
  - req=0000: stay IDLE.
  - req≠0: winner → gnt_idx, gnt_valid=1, cnt=1, ptr=winner+1 mod 4, go to GRANT.
  - Latency from req to gnt is exactly 1 cycle.
- GRANT (owner = gnt_idx), decided at each edge in this order:
  1. req[owner]=0 and other≠0: switch directly to other-winner. Back-to-back, no dead cycle. cnt=1, ptr=new+1.
  2. req[owner]=0 and other=0: gnt_valid=0, go to IDLE. gnt_idx unchanged; cnt=0.
  3. req[owner]=1 and cnt≥HOLD_MAX and other≠0: preempt to other-winner. cnt=1, ptr=new+1.
  4. req[owner]=1 otherwise: keep grant. cnt=cnt+1, saturating at HOLD_MAX (no wrap).
- Grant encoding:
  - gnt is never multi-hot; this is guaranteed by the decoder structure.
  - gnt changes only at clock edges, because its inputs are registered.
- Simultaneous events:
  - Owner drops while others rise in the same cycle: rule 1 applies.
  - All four assert from IDLE: winner is ptr.
- HOLD_MAX=1: the owner is preempted every cycle under contention (pure round-robin).
- ptr wrap: 3+1 → 0.

Test Plan:
- Reset: rst=1 for 2 cycles with req=1111 → gnt=0000, gnt_valid=0, gnt_idx=00; first edge after rst=0 → gnt=0001, gnt_idx=00.
- Single requester: req=0100 from IDLE → gnt=0100 one cycle later; hold req 20 cycles → gnt stays 0100 (no preemption, cnt saturates at 8); req=0000 → next edge gnt=0000, gnt_valid=0.
- Rotation: req=1111 held, HOLD_MAX=8 → grants 0001 ×8, 0010 ×8, 0100 ×8, 1000 ×8, then 0001 again (ptr wraps).
- Back-to-back release: owner 0 granted, req goes 0001→1010 in one cycle → next edge gnt=0010, no idle cycle; then req=1000 → gnt=1000.
- Fairness after idle: grant 2 completes, idle 3 cycles, then req=0101 → gnt=0001? No: ptr=3, scan 3,0 → gnt=0001; next contention picks 0100.
- Mid-grant reset: gnt=1000 with cnt=5, pulse rst=1 one cycle with req=1000 → gnt=0000 at that edge; next edge gnt=1000 again with cnt=1 (preemption only after 8 more cycles).
